// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ byte producers.
// Optional post-frame idle gap is enabled by defining UART_TX_GAP_EN.
module uart_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int TIMEOUT    = 16,
  parameter int GAP_CYCLES = 8,
  localparam int IDXW      = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [IDXW-1:0]   owner,
  output logic              active
);

  // One counter serves both the busy timeout and the gap, so size it for the larger
  localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
`ifdef UART_TX_GAP_EN
    , GAP
`endif
  } state_t;

  state_t           state, state_next;
  logic [CNTW-1:0]  cnt, cnt_next;
  logic [IDXW-1:0]  last, last_next;
  logic [NREQ-1:0]  gnt_next, done_next;
  logic             err_next, tx_start_next, active_next;
  logic [7:0]       tx_data_next;
  logic [IDXW-1:0]  owner_next;

  logic             found;
  logic [IDXW-1:0]  sel;
  logic [IDXW:0]    cand;
  logic [7:0]       sel_byte;

  // Scan last+1, last+2, ... wrapping at NREQ; first requester found wins
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last} + (IDXW+1)'(i);
      if (cand >= (IDXW+1)'(NREQ)) begin
        cand = cand - (IDXW+1)'(NREQ);
      end
      if (!found && req[cand[IDXW-1:0]]) begin
        found = 1'b1;
        sel   = cand[IDXW-1:0];
      end
    end
  end

  assign sel_byte = data[{sel, 3'b000} +: 8];

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    last_next     = last;
    gnt_next      = '0;
    done_next     = '0;
    err_next      = 1'b0;
    tx_start_next = 1'b0;
    tx_data_next  = tx_data;
    owner_next    = owner;
    case (state)
      IDLE: begin
        if (en && found) begin
          gnt_next      = {{(NREQ-1){1'b0}}, 1'b1} << sel;
          tx_start_next = 1'b1;
          tx_data_next  = sel_byte;
          owner_next    = sel;
          cnt_next      = CNTW'(1);
          state_next    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (cnt == CNTW'(TIMEOUT)) begin
          // Tx never started: drop the frame, no done, and skip any gap
          err_next   = 1'b1;
          last_next  = owner;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          done_next  = {{(NREQ-1){1'b0}}, 1'b1} << owner;
          last_next  = owner;
`ifdef UART_TX_GAP_EN
          cnt_next   = CNTW'(1);
          state_next = GAP;
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef UART_TX_GAP_EN
      GAP: begin
        if (cnt >= CNTW'(GAP_CYCLES)) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
    active_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= IDXW'(NREQ - 1);
      gnt      <= '0;
      done     <= '0;
      err      <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      owner    <= '0;
      active   <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      last     <= last_next;
      gnt      <= gnt_next;
      done     <= done_next;
      err      <= err_next;
      tx_start <= tx_start_next;
      tx_data  <= tx_data_next;
      owner    <= owner_next;
      active   <= active_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple Tx busy model.
// Expected gap timing follows UART_TX_GAP_EN when it is defined for the build.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
`ifdef UART_TX_GAP_EN
  localparam int EXP_GAP = 9;
`else
  localparam int EXP_GAP = 1;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic [NREQ-1:0] req;
  logic [NREQ*8-1:0] data;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic            err;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic [1:0]      owner;
  logic            active;

  logic            model_en;
  logic            model_busy;
  logic [7:0]      busy_cnt;
  logic            busy_glitch;

  int num_checks = 0;
  int num_fails  = 0;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(16), .GAP_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .data(data),
    .gnt(gnt), .done(done), .err(err), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .owner(owner), .active(active)
  );

  always #5 clk = ~clk;

  // Tx model: busy rises one clock after tx_start and stays high for 80 clocks
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_busy <= 1'b0;
      busy_cnt   <= '0;
    end else if (tx_start && model_en) begin
      model_busy <= 1'b1;
      busy_cnt   <= 8'd79;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 8'd1;
    end else begin
      model_busy <= 1'b0;
    end
  end

  assign tx_busy = model_busy | busy_glitch;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitForGnt(input logic [3:0] exp_gnt, input logic [7:0] exp_byte,
                            input logic [1:0] exp_owner, input string tag);
    int n = 0;
    while (gnt == 0 && n < 40) begin
      tick();
      n++;
    end
    checkOutput({tag, " gnt"}, gnt, exp_gnt);
    checkOutput({tag, " tx_start"}, tx_start, 1);
    checkOutput({tag, " tx_data"}, tx_data, exp_byte);
    checkOutput({tag, " owner"}, owner, exp_owner);
  endtask

  task automatic waitDone(input logic [3:0] exp_done, input string tag);
    int n = 0;
    int extra = 0;
    while (!tx_busy && n < 200) begin
      tick();
      n++;
      if (gnt != 0) extra++;
    end
    while (tx_busy && n < 200) begin
      tick();
      n++;
      if (gnt != 0) extra++;
    end
    checkOutput({tag, " bounded"}, n < 200, 1);
    checkOutput({tag, " extra gnt"}, extra, 0);
    checkOutput({tag, " done early"}, done, 0);
    tick();
    checkOutput({tag, " done"}, done, exp_done);
    checkOutput({tag, " gnt with done"}, gnt, 0);
  endtask

  task automatic measureGap(input string tag);
    int n = 0;
    while (!tx_start && n < 30) begin
      tick();
      n++;
      if (n == 1) checkOutput({tag, " done pulse width"}, done, 0);
    end
    checkOutput({tag, " done to tx_start"}, n, EXP_GAP);
  endtask

  task automatic applyStimulus();
    logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    int cnt;

    // Reset state
    reset = 1'b0; en = 1'b0; req = '0; data = '0;
    model_en = 1'b1; busy_glitch = 1'b0;
    tick(); tick();
    checkOutput("reset gnt", gnt, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset tx_start", tx_start, 0);
    checkOutput("reset tx_data", tx_data, 0);
    checkOutput("reset owner", owner, 0);
    checkOutput("reset active", active, 0);
    reset = 1'b1;
    tick();

    // Test 1: single request from client 2
    data = 32'h00A5_0000; req = 4'b0100; en = 1'b1;
    tick();
    checkOutput("t1 gnt", gnt, 4'b0100);
    checkOutput("t1 tx_start", tx_start, 1);
    checkOutput("t1 tx_data", tx_data, 8'hA5);
    checkOutput("t1 owner", owner, 2);
    checkOutput("t1 active", active, 1);
    req = '0;
    tick();
    checkOutput("t1 gnt pulse", gnt, 0);
    checkOutput("t1 tx_start pulse", tx_start, 0);
    checkOutput("t1 tx_data held", tx_data, 8'hA5);
    waitDone(4'b0100, "t1");
    tick();
    checkOutput("t1 done pulse", done, 0);

    // Test 2: all four requesting, fresh pointer
    reset = 1'b0; tick(); reset = 1'b1;
    data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      waitForGnt(4'b0001 << order[f], bytes[f], order[f], $sformatf("t2 f%0d", f));
      if (f == 4) req = '0;
      waitDone(4'b0001 << order[f], $sformatf("t2 f%0d", f));
      if (f < 4) measureGap($sformatf("t2 f%0d", f));
    end

    // Test 3: serve client 1, then 1010 must go to client 3 first
    req = 4'b0010;
    waitForGnt(4'b0010, 8'h22, 2'd1, "t3 a");
    req = '0;
    waitDone(4'b0010, "t3 a");
    req = 4'b1010;
    waitForGnt(4'b1000, 8'h44, 2'd3, "t3 b");
    req = 4'b0010;
    waitDone(4'b1000, "t3 b");
    waitForGnt(4'b0010, 8'h22, 2'd1, "t3 c");
    req = '0;
    waitDone(4'b0010, "t3 c");

    // Test 4: Tx never goes busy, err after 16 cycles, pending client next
    model_en = 1'b0;
    req = 4'b0001;
    waitForGnt(4'b0001, 8'h11, 2'd0, "t4 a");
    req = 4'b0100;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (err) checkOutput($sformatf("t4 early err @%0d", i), err, 0);
    end
    checkOutput("t4 err before timeout", err, 0);
    tick();
    checkOutput("t4 err", err, 1);
    checkOutput("t4 no done", done, 0);
    checkOutput("t4 active at err", active, 0);
    model_en = 1'b1;
    tick();
    checkOutput("t4 err pulse", err, 0);
    checkOutput("t4 next gnt", gnt, 4'b0100);
    checkOutput("t4 next tx_data", tx_data, 8'h33);
    req = '0;
    waitDone(4'b0100, "t4 b");

    // Test 5: reset during WAIT_DONE
    req = 4'b0010;
    waitForGnt(4'b0010, 8'h22, 2'd1, "t5 a");
    req = '0;
    cnt = 0;
    while (!tx_busy && cnt < 10) begin tick(); cnt++; end
    repeat (5) tick();
    checkOutput("t5 active mid frame", active, 1);
    reset = 1'b0;
    #1;
    checkOutput("t5 async owner", owner, 0);
    checkOutput("t5 async tx_data", tx_data, 0);
    checkOutput("t5 async active", active, 0);
    tick(); tick();
    checkOutput("t5 no done", done, 0);
    checkOutput("t5 no err", err, 0);
    reset = 1'b1;
    req = 4'b1001;
    waitForGnt(4'b0001, 8'h11, 2'd0, "t5 b");
    req = 4'b1000;
    waitDone(4'b0001, "t5 b");
    waitForGnt(4'b1000, 8'h44, 2'd3, "t5 c");
    req = '0;
    waitDone(4'b1000, "t5 c");

    // Test 6: en low blocks new grants
    en = 1'b0;
    req = 4'b0001;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt != 0) cnt++;
    end
    checkOutput("t6 no gnt while en=0", cnt, 0);
    checkOutput("t6 idle while en=0", active, 0);
    en = 1'b1;
    tick();
    checkOutput("t6 gnt", gnt, 4'b0001);
    checkOutput("t6 tx_data", tx_data, 8'h11);
    req = '0;
    en = 1'b0;
    waitDone(4'b0001, "t6");
    en = 1'b1;

    // Test 7: busy glitch while idle is ignored
    repeat (12) tick();
    busy_glitch = 1'b1;
    tick();
    busy_glitch = 1'b0;
    tick(); tick();
    checkOutput("t7 active", active, 0);
    checkOutput("t7 done", done, 0);
    checkOutput("t7 err", err, 0);
    checkOutput("t7 gnt", gnt, 0);
  endtask

  initial begin
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
